// File: rtl/cla_slice_add_seq_pkg.sv
// Shared constants for the slice-sequenced add/subtract unit.
package cla_slice_add_seq_pkg;
    localparam int SLICE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_slice_add_seq_cla8.sv
// 8-bit carry-lookahead adder slice; each carry is a flat sum of generate/propagate terms.
module CLAAdder8b
    import cla_slice_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               CIN,
    output logic [SLICE_W-1:0] S,
    output logic               COUT
);
    logic [SLICE_W-1:0] p, g;
    logic [SLICE_W:0]   c;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        logic pp;
        c    = '0;
        c[0] = CIN;
        for (int i = 0; i < SLICE_W; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, no ripple chain
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & CIN);
        end
    end

    assign S    = p ^ c[SLICE_W-1:0];
    assign COUT = c[SLICE_W];
endmodule

// File: rtl/cla_slice_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one 8-bit CLA slice, LSB slice first.
module cla_slice_add_seq
    import cla_slice_add_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_W   // must equal SLICE_W; WIDTH must be a multiple of it
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;
    logic [SLICE-1:0] s;
    logic             s_cout, last, c_msb;
    logic [WIDTH-1:0] res_next;

    CLAAdder8b u_slice (
        .A    (opa[idx*SLICE +: SLICE]),
        .B    (opb[idx*SLICE +: SLICE]),
        .CIN  (carry),
        .S    (s),
        .COUT (s_cout)
    );

    assign last      = (idx == LAST_IDX);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // Carry into the MSB recovered from the MSB sum bit, so no internal slice carry is needed.
    assign c_msb     = opa[WIDTH-1] ^ opb[WIDTH-1] ^ s[SLICE-1];

    always_comb begin
        res_next = result;
        res_next[idx*SLICE +: SLICE] = s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa   <= a;
                    opb   <= (sub == OP_SUB) ? ~b : b;
                    carry <= sub;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    result <= res_next;
                    carry  <= s_cout;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        cout  <= s_cout;
                        ovf   <= c_msb ^ s_cout;
                        zero  <= (res_next == '0);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_slice_add_seq.sv
// Directed-vector bench for cla_slice_add_seq with hand-computed expectations.
module tb_cla_slice_add_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        cout, ovf, zero;

    int checks = 0;
    int errors = 0;

    cla_slice_add_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Issue one operation and count cycles from the accept edge to out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                          output int lat);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL run_op_in_ready: got %b want 1", in_ready);
        end
        a = ta; b = tb_; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL consume: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic check_res(input string nm, input int lat, input logic [31:0] er,
                             input logic ec, input logic eo, input logic ez);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL %s_latency: got %0d want 4", nm, lat); end
        checks++;
        if (result !== er) begin errors++; $display("FAIL %s_result: got %h want %h", nm, result, er); end
        checks++;
        if (cout !== ec) begin errors++; $display("FAIL %s_cout: got %b want %b", nm, cout, ec); end
        checks++;
        if (ovf !== eo) begin errors++; $display("FAIL %s_ovf: got %b want %b", nm, ovf, eo); end
        checks++;
        if (zero !== ez) begin errors++; $display("FAIL %s_zero: got %b want %b", nm, zero, ez); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++;
        if ({cout, ovf, zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_carry();
        int lat;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        check_res("add_carry", lat, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_full_ripple();
        int lat;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check_res("ripple", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        consume();
    endtask

    task automatic test_overflow_sub();
        int lat;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check_res("ovf", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        consume();
        run_op(32'd5, 32'd7, 1'b1, lat);
        check_res("sub5_7", lat, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        consume();
        run_op(32'd7, 32'd5, 1'b1, lat);
        check_res("sub7_5", lat, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        consume();
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        check_res("sub_ovf", lat, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(32'd3, 32'd4, 1'b0, lat);
        check_res("bp", lat, 32'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'hAAAA_0000 + i; b = 32'h1111_1111; sub = i[0];
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd7 ||
                {cout, ovf, zero} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b result=%h flags=%b want 0/1/7/000",
                         i, in_ready, out_valid, result, {cout, ovf, zero});
            end
        end
        // in_valid still high alongside out_ready: only the result handshake may complete.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd7) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b result=%h want 1/0/7",
                     in_ready, out_valid, result);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_capture: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;    // now in the 2nd RUN cycle
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL abort_immediate: in_ready=%b out_valid=%b result=%h want 1/0/0",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_valid: out_valid pulsed, want never"); end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        check_res("after_abort", lat, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        consume();
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_full_ripple();
        test_overflow_sub();
        test_backpressure();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_slice_add_seq.md
Name: cla_slice_add_seq

Overview:
- Multi-cycle add/subtract sequencer for the decode-stage address/immediate path.
- Time-shares one 8-bit carry-lookahead slice adder (CLAAdder8b) over a WIDTH-bit operation, one slice per cycle, LSB first.
- Carry is chained through a register between slices.
- Valid/ready handshake on both the operand side and the result side; one operation in flight.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, slice width; fixed to match CLAAdder8b.
- NSLICES, WIDTH/SLICE (4), derived; number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - result, cout, ovf, zero, out_valid, slice index and carry register all 0.
  - in_ready = 1 once reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept on in_valid & in_ready at a rising edge:
    - opA <= a; opB <= sub ? ~b : b; carry <= sub; idx <= 0.
    - Go to RUN.
  - Without a handshake, stay in IDLE and ignore inputs.
- RUN:
  - in_ready = 0.
  - Each cycle the slice adder sees opA[idx], opB[idx], CIN = carry.
  - Each edge: result[idx] <= S; carry <= COUT; idx <= idx+1.
  - After slice NSLICES-1 is written, go to DONE.
  - a, b, sub and in_valid are ignored during RUN.
- Flags, registered on the final RUN edge:
  - cout = final COUT.
  - c_msb = opA[WIDTH-1] ^ opB[WIDTH-1] ^ S[SLICE-1] (carry into the MSB); ovf = c_msb ^ COUT.
  - zero = (full result == 0), evaluated on the complete word including the final slice.
- Latency: out_valid rises exactly NSLICES (4) cycles after the accepting edge.
- DONE:
  - out_valid = 1; result and flags held stable.
  - Leave only on out_valid & out_ready, then go to IDLE.
  - in_ready returns to 1 in the following cycle; no back-to-back overlap.
  - result and flags keep their values until the next operation overwrites them.
- Backpressure: out_ready low holds DONE indefinitely with no output change.
- Wrap-around: modulo 2^WIDTH; carry propagates across every slice boundary, e.g. 0xFFFFFFFF+1 ripples through all 4 slices.
- Reset mid-operation: reset asserted in RUN or DONE aborts immediately. The partial result is discarded, out_valid never pulses for the aborted operation, and the next accepted operation is unaffected.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; operands are not accepted in DONE.

Decomposition:
- Shared package holds:
  - SLICE_W = 8.
  - State encoding localparams IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Op encoding OP_ADD = 1'b0, OP_SUB = 1'b1.
- Natural sub-module: exactly one instance of the existing CLAAdder8b as the datapath slice.
- Slice mux/demux, carry register, FSM and flag logic live in cla_slice_add_seq.

Test Plan:
- Reset: assert reset for 3 cycles, then release -> out_valid=0, result=0, flags=0, in_ready=1.
- Add with carry and latency check: a=0x000000FF, b=0x00000001, sub=0 -> result 0x00000100, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Full ripple: a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, cout=1, zero=1, ovf=0.
- Overflow and subtract:
  - 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0.
  - Subtract 5-7 -> 0xFFFFFFFE, cout=0, ovf=0.
  - Subtract 7-5 -> 0x00000002, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles while driving in_valid=1 with new operands -> in_ready=0 throughout; result/flags unchanged; new operands not captured. After out_ready=1, in_ready=1 the next cycle.
- Abort: assert reset on the 2nd RUN cycle of 0x12345678+0x11111111 -> immediate IDLE, out_valid never asserts. A following 0x12345678+0x11111111 yields 0x23456789.
